// File: rtl/timer_sched.sv
// Round-robin owner of one shared countdown timer: arbitrates levelled requests, loads the timer and gates beats into it.
// Optional build macro TIMER_SCHED_ABORT_EN: an owner that drops req during LOAD/RUN releases the timer without an ack.
module timer_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     beat,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_val,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         ack,
    output logic                     busy,
    output logic                     tmr_load,
    output logic [WIDTH-1:0]         tmr_load_val,
    output logic                     tmr_count_en,
    input  logic                     tmr_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_next;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_owner_next;
    logic [IDX_W-1:0]   w_owner_inc;
    logic [IDX_W-1:0]   w_pick;
    logic               w_found;
    logic               w_owner_req;
    logic [WIDTH-1:0]   r_val_q;
    logic [WIDTH-1:0]   w_val_next;
    logic [WIDTH-1:0]   w_pick_val;
    logic [N_REQ-1:0]   w_owner_onehot;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   w_grant_next;
    logic [N_REQ-1:0]   r_ack;
    logic [N_REQ-1:0]   w_ack_next;
    logic               r_busy;
    logic               r_tmr_load;

    // Index arithmetic modulo N_REQ, valid for non-power-of-two requester counts.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Scan downward so the lowest offset from the pointer is the one that sticks.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(r_ptr, k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_add(r_ptr, k);
            end
        end
    end

    assign w_pick_val  = req_val[w_pick*WIDTH +: WIDTH];
    assign w_owner_inc = wrap_add(r_owner, 1);
    assign w_owner_req = req[r_owner];

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_owner_next = r_owner;
        w_val_next   = r_val_q;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_owner_next = w_pick;
                    w_val_next   = w_pick_val;
                    w_state_next = (w_pick_val == '0) ? ACK : LOAD;
                end
            end
            LOAD: w_state_next = RUN;
            RUN: begin
                if (tmr_done) begin
                    w_state_next = ACK;
                end
            end
            ACK: begin
                w_ptr_next   = w_owner_inc;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
`ifdef TIMER_SCHED_ABORT_EN
        if (((r_state == LOAD) || (r_state == RUN)) && !w_owner_req) begin
            w_ptr_next   = w_owner_inc;
            w_state_next = IDLE;
        end
`endif
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
            assign w_owner_onehot[gi] = (w_owner_next == GI_IDX);
        end
    endgenerate

    // Outputs are decoded from the next state so they appear registered in the cycle the state is entered.
    assign w_grant_next = (w_state_next != IDLE) ? w_owner_onehot : '0;
    assign w_ack_next   = (w_state_next == ACK)  ? w_owner_onehot : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_val_q    <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_tmr_load <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_owner    <= w_owner_next;
            r_val_q    <= w_val_next;
            r_grant    <= w_grant_next;
            r_ack      <= w_ack_next;
            r_busy     <= (w_state_next != IDLE);
            r_tmr_load <= (w_state_next == LOAD);
        end
    end

    assign grant        = r_grant;
    assign ack          = r_ack;
    assign busy         = r_busy;
    assign tmr_load     = r_tmr_load;
    assign tmr_load_val = r_val_q;
    assign tmr_count_en = beat & (r_state == RUN);

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with a behavioural countdown timer and a per-cycle service-level reference.
module tb_timer_sched;

    localparam int N_REQ = 4;
    localparam int WIDTH = 4;
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_ACK  = 3;
`ifdef TIMER_SCHED_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   beat = 1'b0;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] req_val = '0;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       ack;
    logic                   busy;
    logic                   tmr_load;
    logic [WIDTH-1:0]       tmr_load_val;
    logic                   tmr_count_en;
    logic                   tmr_done;

    logic                   beat_auto = 1'b0;
    logic                   beat_manual = 1'b0;
    logic                   done_force = 1'b0;
    logic [WIDTH-1:0]       tm_cnt = '0;
    logic                   tm_armed = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int load_cnt = 0;

    // Reference: which service is in progress and at what stage.
    int               m_phase = PH_IDLE;
    int               m_owner = 0;
    int               m_ptr = 0;
    logic [WIDTH-1:0] m_val = '0;
    int               m_pick;
    logic [N_REQ-1:0] e_grant;
    logic [N_REQ-1:0] e_ack;

    always #5 clk = ~clk;

    timer_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .beat         (beat),
        .req          (req),
        .req_val      (req_val),
        .grant        (grant),
        .ack          (ack),
        .busy         (busy),
        .tmr_load     (tmr_load),
        .tmr_load_val (tmr_load_val),
        .tmr_count_en (tmr_count_en),
        .tmr_done     (tmr_done)
    );

    // Shared countdown timer: load wins, counts down on enable, done once it reaches zero.
    assign tmr_done = done_force | (tm_armed & (tm_cnt == '0));

    always @(posedge clk) begin
        if (tmr_load) begin
            tm_cnt   <= tmr_load_val;
            tm_armed <= 1'b1;
        end else if (tmr_count_en && (tm_cnt != '0)) begin
            tm_cnt <= tm_cnt - 1'b1;
        end
    end

    initial begin
        logic ph;
        ph = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (beat_auto) begin
                ph   = ~ph;
                beat = ph;
            end else begin
                beat = beat_manual;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int arb_pick(input logic [N_REQ-1:0] r, input int p);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(p + k) % N_REQ]) begin
                return (p + k) % N_REQ;
            end
        end
        return -1;
    endfunction

    // Compare process: check this cycle's outputs, then advance the reference using the inputs present at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_phase = PH_IDLE;
                m_owner = 0;
                m_ptr   = 0;
                m_val   = '0;
            end
            e_grant = (m_phase != PH_IDLE) ? N_REQ'(1 << m_owner) : '0;
            e_ack   = (m_phase == PH_ACK)  ? N_REQ'(1 << m_owner) : '0;
            chk("grant", grant, e_grant);
            chk("ack", ack, e_ack);
            chk("busy", busy, (m_phase != PH_IDLE));
            chk("tmr_load", tmr_load, (m_phase == PH_LOAD));
            chk("tmr_load_val", tmr_load_val, m_val);
            chk("tmr_count_en", tmr_count_en, (m_phase == PH_RUN) && beat);
            if (tmr_load) load_cnt++;
            if (rst) begin
                if (ABORT_EN && ((m_phase == PH_LOAD) || (m_phase == PH_RUN)) && !req[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N_REQ;
                    m_phase = PH_IDLE;
                end else begin
                    case (m_phase)
                        PH_IDLE: begin
                            m_pick = arb_pick(req, m_ptr);
                            if (m_pick >= 0) begin
                                m_owner = m_pick;
                                m_val   = req_val[m_pick*WIDTH +: WIDTH];
                                m_phase = (m_val == '0) ? PH_ACK : PH_LOAD;
                            end
                        end
                        PH_LOAD: m_phase = PH_RUN;
                        PH_RUN:  if (tmr_done) m_phase = PH_ACK;
                        default: begin
                            m_ptr   = (m_owner + 1) % N_REQ;
                            m_phase = PH_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // Waits up to max cycles for tmr_load (which=0) or any ack (which=1); n=0 on timeout.
    task automatic wait_ev(input int which, input int max, output int n, output logic pd);
        logic hit;
        n  = 0;
        pd = 1'b0;
        for (int i = 1; (i <= max) && (n == 0); i++) begin
            @(negedge clk);
            hit = (which == 0) ? tmr_load : (|ack);
            if (hit) n = i;
            else     pd = tmr_done;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic pd;
        int lc0;
        int order [5];
        order = '{0, 1, 2, 3, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmr_load", tmr_load, 0);
        chk("rst_tmr_load_val", tmr_load_val, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single requester, delay 1, beat every other cycle.
        req_val   = 16'h0001;
        beat_auto = 1'b1;
        req       = 4'b0001;
        wait_ev(0, 10, n, pd);
        chk("t1_req_to_load", n, 2);
        chk("t1_load_val", tmr_load_val, 1);
        chk("t1_grant", grant, 4'b0001);
        @(negedge clk);
        chk("t1_load_one_cycle", tmr_load, 0);
        wait_ev(1, 40, n, pd);
        chk("t1_ack_seen", (n != 0), 1);
        chk("t1_ack", ack, 4'b0001);
        chk("t1_done_cycle_before_ack", pd, 1);
        @(posedge clk);
        #1 req = 4'b0000;
        do_reset();

        // All four requesting: rotation 0,1,2,3,0 with one idle cycle between services.
        req_val = 16'h5432;
        req     = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            wait_ev(0, 10, n, pd);
            chk("t2_gap_to_load", n, 2);
            chk("t2_grant_order", grant, (32'd1 << order[s]));
            wait_ev(1, 40, n, pd);
            chk("t2_ack_order", ack, (32'd1 << order[s]));
        end
        @(posedge clk);
        #1 req = 4'b0000;

        // Zero delay for requester 2: ack without any load.
        @(posedge clk);
        #1 req_val = 16'h5032;
        req = 4'b0100;
        lc0 = load_cnt;
        wait_ev(1, 10, n, pd);
        chk("t3_req_to_ack", n, 2);
        chk("t3_ack", ack, 4'b0100);
        chk("t3_grant", grant, 4'b0100);
        @(posedge clk);
        #1 req = 4'b0000;
        @(negedge clk);
        chk("t3_no_load", load_cnt - lc0, 0);
        chk("t3_idle", busy, 0);

        // done pulse while idle, then a beat held through IDLE and LOAD.
        @(posedge clk);
        #1 beat_auto = 1'b0;
        done_force = 1'b1;
        @(negedge clk);
        chk("t4_done_idle_busy", busy, 0);
        @(posedge clk);
        #1 done_force = 1'b0;
        @(negedge clk);
        chk("t4_after_done_busy", busy, 0);
        chk("t4_after_done_grant", grant, 0);
        @(posedge clk);
        #1 req_val = 16'h1032;
        req = 4'b1000;
        beat_manual = 1'b1;
        @(negedge clk);
        chk("t4_cen_idle", tmr_count_en, 0);
        @(negedge clk);
        chk("t4_load", tmr_load, 1);
        chk("t4_cen_load", tmr_count_en, 0);
        chk("t4_grant", grant, 4'b1000);
        @(posedge clk);
        #1 beat_manual = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_beat_dropped_busy", busy, 1);
        chk("t4_beat_dropped_ack", ack, 0);
        @(posedge clk);
        #1 beat_auto = 1'b1;
        wait_ev(1, 20, n, pd);
        chk("t4_ack_seen", (n != 0), 1);
        chk("t4_ack", ack, 4'b1000);
        @(posedge clk);
        #1 req = 4'b0000;

        // Owner drops its request during RUN.
        @(posedge clk);
        #1 req_val = 16'h1035;
        req = 4'b0001;
        wait_ev(0, 10, n, pd);
        chk("t5_req_to_load", n, 2);
        chk("t5_grant", grant, 4'b0001);
        @(posedge clk);
        @(posedge clk);
        #1 req = 4'b0000;
        @(negedge clk);
        chk("t5_busy_at_drop", busy, 1);
        @(negedge clk);
`ifdef TIMER_SCHED_ABORT_EN
        chk("t5_busy_after_abort", busy, 0);
        wait_ev(1, 16, n, pd);
        chk("t5_no_ack_after_abort", n, 0);
`else
        chk("t5_busy_after_drop", busy, 1);
        wait_ev(1, 30, n, pd);
        chk("t5_ack_seen", (n != 0), 1);
        chk("t5_ack", ack, 4'b0001);
`endif

        // Asynchronous reset in RUN, then arbitration restarts from requester 0.
        @(posedge clk);
        #1 req = 4'b0010;
        wait_ev(0, 10, n, pd);
        chk("t6_req_to_load", n, 2);
        chk("t6_grant", grant, 4'b0010);
        @(posedge clk);
        #1;
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_ack", ack, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_tmr_load", tmr_load, 0);
        chk("t6_rst_tmr_load_val", tmr_load_val, 0);
        chk("t6_rst_cen", tmr_count_en, 0);
        req = 4'b0011;
        @(posedge clk);
        #1 rst = 1'b1;
        wait_ev(0, 10, n, pd);
        chk("t6_release_to_load", n, 2);
        chk("t6_grant_from_ptr0", grant, 4'b0001);
        chk("t6_load_val", tmr_load_val, 5);
        wait_ev(1, 40, n, pd);
        chk("t6_ack", ack, 4'b0001);
        @(posedge clk);
        #1 req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
